run_controller: RTL

Run/halt/error sequencer for the single-cycle core. It sits between the CPU's exception vector and the PC register and decides each cycle whether the PC loads the CPU's next PC, stalls, or is redirected. It latches the halting PC and cause for the seven-segment display and keeps cycle and retired-instruction counters. Debug run, halt and step requests come from the bench or board buttons.

---
 rtl/run_ctrl_pkg.sv | 25 ++
 rtl/ctrl_counter.sv | 31 +++
 rtl/run_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg
// Shared definitions for the run/halt/error sequencer of the single-cycle core.
// Contents:
//   state_e          - sequencer state, encoding visible on state_o
//   FETCH_ERR..EBREAK - bit positions inside the CPU exception vector
//   DEFAULT_RESET_PC - PC loaded when the core leaves reset
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_HALT  = 3'd2,
        ST_ERROR = 3'd3,
        ST_STEP  = 3'd4
    } state_e;

    localparam int FETCH_ERR  = 0;
    localparam int DECODE_ERR = 1;
    localparam int ANOMALY    = 2;
    localparam int ECALL      = 3;
    localparam int EBREAK     = 4;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/ctrl_counter.sv
// ctrl_counter
// Free-running enable-gated counter that wraps silently at 2^CNT_WIDTH.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset, clears the count
//   en_i    - count enable, one increment per enabled cycle
//   count_o - current count value
module ctrl_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q;

    // Plain binary increment; overflow simply rolls over to zero so the
    // counters behave like the architectural mcycle/minstret registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/run_controller.sv
// run_controller
// Decides every cycle whether the PC register loads the CPU's next PC, holds,
// or is redirected; latches the halting PC and cause for the display and keeps
// cycle / retired-instruction counters.
// Build option: define RUN_CTRL_STEP_EN to enable single-step (STEP state);
// without it step_req_i is ignored and STEP can never be entered.
// Ports:
//   clk_i, rst_ni   - clock and asynchronous active-low reset
//   exception_i     - CPU exception vector (bits 7:5 are don't-care)
//   pc_i, new_pc_i  - current PC and CPU-computed next PC
//   run_req_i, halt_req_i, step_req_i - level-sampled debug requests
//   pc_we_o, pc_next_o - PC register write enable and load value
//   state_o         - sequencer state
//   epc_o, cause_o  - PC and exception vector captured at the last halt/error
//   cycle_o, instret_o - RUN/STEP cycle count and committed-instruction count
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    CNT_WIDTH  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [7:0]            exception_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] new_pc_i,
    input  logic                  run_req_i,
    input  logic                  halt_req_i,
    input  logic                  step_req_i,
    output logic                  pc_we_o,
    output logic [DATA_WIDTH-1:0] pc_next_o,
    output logic [2:0]            state_o,
    output logic [DATA_WIDTH-1:0] epc_o,
    output logic [7:0]            cause_o,
    output logic [CNT_WIDTH-1:0]  cycle_o,
    output logic [CNT_WIDTH-1:0]  instret_o
);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   epc_q, epc_d;
    logic [7:0]              cause_q, cause_d;
    logic                    pcWe;
    logic [DATA_WIDTH-1:0]   pcNext;
    logic                    commit;
    logic                    executing;
    logic                    trapResume;

`ifndef RUN_CTRL_STEP_EN
    logic unusedStepReq;
    assign unusedStepReq = step_req_i;
`endif

    // A halt caused by ECALL/EBREAK must skip the trapping instruction when
    // resuming; a requested halt resumes at the PC that was never overwritten.
    assign trapResume = |cause_q[EBREAK:ECALL];
    assign executing  = (state_q == ST_RUN) || (state_q == ST_STEP);

    // Combinational decision for the current cycle. Errors outrank traps,
    // traps outrank a debug halt request, and only a clean cycle commits.
    // A STEP cycle behaves like RUN but parks in HALT after its single commit,
    // recording the PC it will resume from.
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        pcWe    = 1'b0;
        pcNext  = pc_i;
        commit  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                pcWe    = 1'b1;
                pcNext  = RESET_PC;
                state_d = ST_RUN;
            end
            ST_RUN, ST_STEP: begin
                if (|exception_i[ANOMALY:FETCH_ERR]) begin
                    state_d = ST_ERROR;
                    epc_d   = pc_i;
                    cause_d = exception_i;
                end else if (exception_i[ECALL] || exception_i[EBREAK]) begin
                    state_d = ST_HALT;
                    epc_d   = pc_i;
                    cause_d = exception_i;
                end else if (halt_req_i) begin
                    state_d = ST_HALT;
                    epc_d   = pc_i;
                    cause_d = '0;
                end else begin
                    pcWe   = 1'b1;
                    pcNext = new_pc_i;
                    commit = 1'b1;
                    if (state_q == ST_STEP) begin
                        state_d = ST_HALT;
                        epc_d   = new_pc_i;
                        cause_d = '0;
                    end
                end
            end
            ST_HALT: begin
                if (run_req_i) begin
                    state_d = ST_RUN;
                    if (trapResume) begin
                        pcWe   = 1'b1;
                        pcNext = epc_q + DATA_WIDTH'(4);
                    end
                end
`ifdef RUN_CTRL_STEP_EN
                else if (step_req_i) begin
                    state_d = ST_STEP;
                    if (trapResume) begin
                        pcWe   = 1'b1;
                        pcNext = epc_q + DATA_WIDTH'(4);
                    end
                end
`endif
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State and the halt-capture registers; reset returns to BOOT so the
    // next cycle reloads the reset PC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_BOOT;
            epc_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    ctrl_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (executing),
        .count_o (cycle_o)
    );

    ctrl_counter #(.CNT_WIDTH(CNT_WIDTH)) u_instret_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (commit),
        .count_o (instret_o)
    );

    assign pc_we_o   = pcWe;
    assign pc_next_o = pcNext;
    assign state_o   = state_q;
    assign epc_o     = epc_q;
    assign cause_o   = cause_q;

endmodule
